// File: rtl/rcv_bit_timer_if.sv
// rcv_bit_timer_if: control/strobe bundle between the receiver FSM/shift
// register (master) and the bit timer (slave).
interface rcv_bit_timer_if #(
   parameter int CYC_BITS = 14,
   parameter int BIT_BITS = 4
);
   logic                start;
   logic                abort;
   logic [CYC_BITS-1:0] bit_period;
   logic [BIT_BITS-1:0] data_size;
   logic                busy;
   logic                sample_strobe;
   logic                shift_strobe;
   logic                packet_done;
   logic [BIT_BITS-1:0] bit_index;

   modport master (
      output start, abort, bit_period, data_size,
      input  busy, sample_strobe, shift_strobe, packet_done, bit_index
   );

   modport slave (
      input  start, abort, bit_period, data_size,
      output busy, sample_strobe, shift_strobe, packet_done, bit_index
   );
endinterface

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: bit-timing sequencer for the serial receiver.
// A cycle counter runs 1..P per bit, a bit counter tracks completed data
// bits; strobes are decoded from registered state only.
// Optional macro RCV_TIMER_STOP_BIT_EN adds a STOP bit period after the
// last data bit (sample strobe only, no shift).
module rcv_bit_timer #(
   parameter int CYC_BITS = 14,
   parameter int BIT_BITS = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   rcv_bit_timer_if.slave      bus
);

   localparam logic [CYC_BITS-1:0] C_ZERO = '0;
   localparam logic [CYC_BITS-1:0] C_ONE  = CYC_BITS'(1);
   localparam logic [CYC_BITS-1:0] C_TWO  = CYC_BITS'(2);
   localparam logic [BIT_BITS-1:0] B_ZERO = '0;
   localparam logic [BIT_BITS-1:0] B_ONE  = BIT_BITS'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
`ifdef RCV_TIMER_STOP_BIT_EN
      , S_STOP = 2'd3
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CYC_BITS-1:0] p_q;        // latched bit period, never below 2
   logic [BIT_BITS-1:0] n_q;        // latched data bit count, never below 1
   logic [CYC_BITS-1:0] c_q, c_d;
   logic [BIT_BITS-1:0] bit_cnt_q, bit_cnt_d;

   logic accept;
   logic timing_q;                  // RUN or STOP, decoded from state_q
   logic timing_d;                  // RUN or STOP, decoded from state_d
   logic bit_end;
   logic last_shift;

   assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;
   assign bit_end = (c_q == p_q);

`ifdef RCV_TIMER_STOP_BIT_EN
   assign timing_q = (state_q == S_RUN) || (state_q == S_STOP);
   assign timing_d = (state_d == S_RUN) || (state_d == S_STOP);
`else
   assign timing_q = (state_q == S_RUN);
   assign timing_d = (state_d == S_RUN);
`endif

   // Strobes depend only on registered state/count, never on inputs.
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.sample_strobe = timing_q && (c_q == (p_q >> 1));
   assign bus.shift_strobe  = (state_q == S_RUN) && bit_end;
   assign bus.packet_done   = (state_q == S_DONE);
   assign bus.bit_index     = bit_cnt_q;

   // bit_cnt_q still holds N-1 on the shift of the final data bit.
   assign last_shift = bus.shift_strobe && (bit_cnt_q == (n_q - B_ONE));

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort overrides everything, including a start.
   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
`ifdef RCV_TIMER_STOP_BIT_EN
            S_RUN:  if (last_shift) state_d = S_STOP;
            S_STOP: if (bit_end) state_d = S_DONE;
`else
            S_RUN:  if (last_shift) state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Counter next values: c restarts at 1 on entry and at each bit wrap;
   // c never exceeds P so the increment cannot overflow CYC_BITS.
   always_comb begin
      c_d       = C_ZERO;
      bit_cnt_d = bit_cnt_q;
      if (timing_d) begin
         if (state_q == S_IDLE || bit_end) c_d = C_ONE;
         else                              c_d = c_q + C_ONE;
      end
      if (state_d == S_IDLE || state_q == S_IDLE) bit_cnt_d = B_ZERO;
      else if (bus.shift_strobe)                  bit_cnt_d = bit_cnt_q + B_ONE;
   end

   // Counters and packet parameters; P and N are frozen on accepted start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         c_q       <= C_ZERO;
         bit_cnt_q <= B_ZERO;
         p_q       <= C_TWO;
         n_q       <= B_ONE;
      end else begin
         c_q       <= c_d;
         bit_cnt_q <= bit_cnt_d;
         if (accept) begin
            p_q <= (bus.bit_period < C_TWO) ? C_TWO : bus.bit_period;
            n_q <= (bus.data_size == B_ZERO) ? B_ONE : bus.data_size;
         end
      end
   end

endmodule

// File: tb/tb_rcv_bit_timer.sv
// tb_rcv_bit_timer: directed and randomized packets checked every cycle
// against an arithmetic timing model of the bit timer.
module tb_rcv_bit_timer;

   localparam int CYC_BITS = 14;
   localparam int BIT_BITS = 4;
   localparam int OW       = 4 + BIT_BITS;
`ifdef RCV_TIMER_STOP_BIT_EN
   localparam int STOP_EN = 1;
`else
   localparam int STOP_EN = 0;
`endif

   logic clk;
   logic n_rst;
   int   checks;
   int   failures;

   rcv_bit_timer_if #(.CYC_BITS(CYC_BITS), .BIT_BITS(BIT_BITS)) bus ();

   rcv_bit_timer #(.CYC_BITS(CYC_BITS), .BIT_BITS(BIT_BITS)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff_p(int p_raw);
      return (p_raw < 2) ? 2 : p_raw;
   endfunction

   function automatic int eff_n(int n_raw);
      return (n_raw < 1) ? 1 : n_raw;
   endfunction

   // Cycle (relative to the accept cycle) carrying packet_done.
   function automatic int done_cycle(int p_raw, int n_raw);
      return (eff_n(n_raw) + STOP_EN) * eff_p(p_raw) + 1;
   endfunction

   // Expected {busy, sample, shift, done, bit_index} at cycle t after accept.
   function automatic logic [OW-1:0] model(int t, int p_raw, int n_raw);
      int p, n, dt, data_end, stop_end, bi;
      logic busy, smp, shf, dn;
      p = eff_p(p_raw);
      n = eff_n(n_raw);
      dt = done_cycle(p_raw, n_raw);
      data_end = n * p;
      stop_end = dt - 1;
      if (t < 1 || t > dt) return '0;
      busy = 1'b1;
      dn   = (t == dt);
      shf  = (t <= data_end) && (t % p == 0);
      smp  = (t <= stop_end) && (t % p == p / 2);
      bi   = (t - 1) / p;
      if (bi > n) bi = n;
      return {busy, smp, shf, dn, BIT_BITS'(bi)};
   endfunction

   function automatic logic [OW-1:0] outs();
      return {bus.busy, bus.sample_strobe, bus.shift_strobe, bus.packet_done, bus.bit_index};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [OW-1:0] obs;
      n_rst = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.bit_period = '0;
      bus.data_size = '0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) n_rst = 1'b1;
         obs = outs();
         checks++;
         if (obs !== '0) begin
            failures++;
            $display("FAIL reset i=%0d got=%h exp=%h", i, obs, {OW{1'b0}});
         end
         tick();
      end
   endtask

   task automatic test_nominal();
      logic [OW-1:0] obs, exp;
      int dt;
      dt = done_cycle(10, 8);
      bus.bit_period = 14'd10;
      bus.data_size = 4'd8;
      bus.start = 1'b1;
      for (int t = 0; t <= dt + 2; t++) begin
         if (t == 1) bus.start = 1'b0;
         exp = model(t, 10, 8);
         obs = outs();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL nominal t=%0d got=%h exp=%h", t, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_degenerate();
      logic [OW-1:0] obs, exp;
      int dt;
      for (int bp = 0; bp < 2; bp++) begin
         dt = done_cycle(bp, 0);
         bus.bit_period = CYC_BITS'(bp);
         bus.data_size = '0;
         bus.start = 1'b1;
         for (int t = 0; t <= dt + 1; t++) begin
            if (t == 1) bus.start = 1'b0;
            exp = model(t, bp, 0);
            obs = outs();
            checks++;
            if (obs !== exp) begin
               failures++;
               $display("FAIL degenerate bp=%0d t=%0d got=%h exp=%h", bp, t, obs, exp);
            end
            tick();
         end
      end
   endtask

   task automatic test_restart_ignored();
      logic [OW-1:0] obs, exp;
      int dt;
      dt = done_cycle(10, 8);
      bus.bit_period = 14'd10;
      bus.data_size = 4'd8;
      bus.start = 1'b1;
      for (int t = 0; t <= dt + 2; t++) begin
         if (t == 1) bus.start = 1'b0;
         if (t == 30) begin
            bus.start = 1'b1;
            bus.bit_period = 14'd4;
            bus.data_size = 4'd3;
         end
         if (t == 31) bus.start = 1'b0;
         exp = model(t, 10, 8);
         obs = outs();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL restart t=%0d got=%h exp=%h", t, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      logic [OW-1:0] obs, exp;
      int dt2;
      dt2 = done_cycle(10, 2);
      bus.bit_period = 14'd10;
      bus.data_size = 4'd8;
      bus.start = 1'b1;
      for (int t = 0; t <= 38 + dt2 + 2; t++) begin
         bus.start = (t == 0 || t == 38);
         bus.abort = (t == 37);
         if (t == 38) bus.data_size = 4'd2;
         exp = (t < 38) ? model(t, 10, 8) : model(t - 38, 10, 2);
         obs = outs();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL abort t=%0d got=%h exp=%h", t, obs, exp);
         end
         tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [OW-1:0] obs, exp;
      bus.bit_period = 14'd10;
      bus.data_size = 4'd8;
      bus.start = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         bus.start = (t == 0 || t == 30);
         bus.abort = (t == 30);
         if (t == 25) begin
            n_rst = 1'b0;
            #1;
         end
         if (t == 28) n_rst = 1'b1;
         exp = (t < 25) ? model(t, 10, 8) : '0;
         obs = outs();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid t=%0d got=%h exp=%h", t, obs, exp);
         end
         tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic test_random();
      logic [OW-1:0] obs, exp;
      int p_raw, n_raw, dt, abort_t, stop_t;
      bit do_abort;
      for (int pk = 0; pk < 10; pk++) begin
         p_raw = $urandom_range(0, 20);
         n_raw = $urandom_range(0, 15);
         do_abort = ($urandom_range(0, 3) == 0);
         dt = done_cycle(p_raw, n_raw);
         abort_t = $urandom_range(1, dt);
         stop_t = do_abort ? abort_t + 2 : dt + 2;
         bus.bit_period = CYC_BITS'(p_raw);
         bus.data_size = BIT_BITS'(n_raw);
         bus.start = 1'b1;
         bus.abort = 1'b0;
         for (int t = 0; t <= stop_t; t++) begin
            if (t > 0) begin
               bus.start = (t <= dt) && !(do_abort && t > abort_t) && ($urandom_range(0, 1) == 1);
               bus.bit_period = CYC_BITS'($urandom_range(0, 30));
               bus.data_size = BIT_BITS'($urandom_range(0, 15));
            end
            bus.abort = do_abort && (t == abort_t);
            exp = (do_abort && t > abort_t) ? '0 : model(t, p_raw, n_raw);
            obs = outs();
            checks++;
            if (obs !== exp) begin
               failures++;
               $display("FAIL random pk=%0d P=%0d N=%0d t=%0d got=%h exp=%h",
                        pk, p_raw, n_raw, t, obs, exp);
            end
            tick();
         end
         bus.start = 1'b0;
         bus.abort = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_nominal();
      test_degenerate();
      test_restart_ignored();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
